// File: rtl/sensor_scheduler_pkg.sv
// sensor_scheduler_pkg: shared encodings and constants for the
// temperature/LDR round-robin scheduler.
package sensor_scheduler_pkg;

    localparam logic high_p = 1'b1;
    localparam logic low_p  = 1'b0;
    localparam int   zero_p = 0;

    localparam logic chan_temp_p = 1'b1;
    localparam logic chan_ldr_p  = 1'b0;

    typedef enum logic [2:0] {
        sched_idle_p        = 3'd0,
        sched_wait_period_p = 3'd1,
        sched_adc_start_p   = 3'd2,
        sched_adc_wait_p    = 3'd3,
        sched_conv_start_p  = 3'd4,
        sched_conv_wait_p   = 3'd5,
        sched_store_p       = 3'd6
    } sched_state_t;

    // One counter serves both the period and the timeout, so it is
    // sized for the larger of the two with a spare bit of headroom.
    function automatic int sched_cnt_width(
        input int period,
        input int timeout
    );
        int top;
        top = (period > timeout) ? period : timeout;
        return $clog2(top) + 1;
    endfunction

endpackage

// File: rtl/sched_timer.sv
// sched_timer: shared period/timeout counter with two terminal-count
// flags; cleared on every scheduler state entry.
module sched_timer
    import sensor_scheduler_pkg::*;
#(
    parameter int SAMPLE_PERIOD_P = 5000000,
    parameter int TIMEOUT_P       = 4096,
    parameter int CNT_W_P         = sched_cnt_width(SAMPLE_PERIOD_P, TIMEOUT_P)
) (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic clear,
    input  logic enable,
    output logic period_done,
    output logic timeout_done
);

    localparam logic [CNT_W_P-1:0] period_last  = CNT_W_P'(SAMPLE_PERIOD_P - 1);
    localparam logic [CNT_W_P-1:0] timeout_last = CNT_W_P'(TIMEOUT_P - 1);

    logic [CNT_W_P-1:0] count;

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W_P'(1);
        end
    end

    assign period_done  = (count == period_last);
    assign timeout_done = (count == timeout_last);

endmodule

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: alternates temperature/LDR ADC conversions, feeds
// each sample to the BCD converter and latches per-channel results.
module sensor_scheduler
    import sensor_scheduler_pkg::*;
#(
    parameter int SAMPLE_PERIOD_P = 5000000,
    parameter int TIMEOUT_P       = 4096,
    parameter int DATA_W_P        = 12,
    parameter int RESULT_W_P      = 16,
    parameter int STAGE_W_P       = 2
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic                  Enable_i,
    output logic                  Adc_Start_o,
    output logic                  Adc_Channel_o,
    input  logic                  Adc_Data_Available_i,
    input  logic [DATA_W_P-1:0]   Adc_Data_i,
    output logic                  Conv_Temp_LDR_o,
    output logic                  Conv_Data_Available_o,
    output logic [DATA_W_P-1:0]   Conv_Data_o,
    input  logic                  Conv_Data_Available_i,
    input  logic [RESULT_W_P-1:0] Conv_Data_i,
    input  logic [STAGE_W_P-1:0]  Conv_Div_Stages_i,
    output logic [RESULT_W_P-1:0] Temp_Result_o,
    output logic [RESULT_W_P-1:0] Ldr_Result_o,
    output logic [STAGE_W_P-1:0]  Temp_Stages_o,
    output logic [STAGE_W_P-1:0]  Ldr_Stages_o,
    output logic                  Result_Valid_o,
    output logic                  Result_Channel_o,
    output logic                  Timeout_Error_o
);

    sched_state_t state;
    sched_state_t state_next;

    logic channel;
    logic timeout_err;
    logic period_done;
    logic timeout_done;
    logic in_adc_wait;
    logic in_conv_wait;
    logic adc_accept;
    logic conv_accept;
    logic timed_out;
    logic timer_clear;
    logic timer_enable;

    assign in_adc_wait  = (state == sched_adc_wait_p);
    assign in_conv_wait = (state == sched_conv_wait_p);
    assign adc_accept   = in_adc_wait && Adc_Data_Available_i;
    assign conv_accept  = in_conv_wait && Conv_Data_Available_i;

    // A done pulse on the terminal wait cycle beats the timeout.
    assign timed_out = timeout_done &&
                       ((in_adc_wait && !Adc_Data_Available_i) ||
                        (in_conv_wait && !Conv_Data_Available_i));

    assign timer_clear  = (state_next != state);
    assign timer_enable = (state == sched_wait_period_p) ||
                          in_adc_wait || in_conv_wait;

    sched_timer #(
        .SAMPLE_PERIOD_P (SAMPLE_PERIOD_P),
        .TIMEOUT_P       (TIMEOUT_P)
    ) u_timer (
        .Clk_i        (Clk_i),
        .Reset_i      (Reset_i),
        .clear        (timer_clear),
        .enable       (timer_enable),
        .period_done  (period_done),
        .timeout_done (timeout_done)
    );

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state <= sched_idle_p;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            sched_idle_p: begin
                if (Enable_i) state_next = sched_adc_start_p;
            end
            sched_wait_period_p: begin
                if (!Enable_i) state_next = sched_idle_p;
                else if (period_done) state_next = sched_adc_start_p;
            end
            sched_adc_start_p: begin
                state_next = sched_adc_wait_p;
            end
            sched_adc_wait_p: begin
                if (adc_accept) state_next = sched_conv_start_p;
                else if (timed_out) state_next = sched_wait_period_p;
            end
            sched_conv_start_p: begin
                state_next = sched_conv_wait_p;
            end
            sched_conv_wait_p: begin
                if (conv_accept) state_next = sched_store_p;
                else if (timed_out) state_next = sched_wait_period_p;
            end
            sched_store_p: begin
                state_next = Enable_i ? sched_wait_period_p : sched_idle_p;
            end
            default: begin
                state_next = sched_idle_p;
            end
        endcase
    end

    always_comb begin
        Adc_Start_o           = low_p;
        Conv_Data_Available_o = low_p;
        Result_Valid_o        = low_p;
        unique case (1'b1)
            (state == sched_adc_start_p):  Adc_Start_o = high_p;
            (state == sched_conv_start_p): Conv_Data_Available_o = high_p;
            (state == sched_store_p):      Result_Valid_o = high_p;
            default: ;
        endcase
    end

    // The channel advances once per round, whether it completed or timed out.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            channel     <= chan_temp_p;
            timeout_err <= low_p;
        end else begin
            if ((state == sched_store_p) || timed_out) begin
                channel <= ~channel;
            end
            if (timed_out) begin
                timeout_err <= high_p;
            end else if ((state == sched_idle_p) && !Enable_i) begin
                timeout_err <= low_p;
            end
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            Conv_Data_o <= '0;
        end else if (adc_accept) begin
            Conv_Data_o <= Adc_Data_i;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            Temp_Result_o    <= '0;
            Ldr_Result_o     <= '0;
            Temp_Stages_o    <= '0;
            Ldr_Stages_o     <= '0;
            Result_Channel_o <= chan_ldr_p;
        end else if (conv_accept) begin
            Result_Channel_o <= channel;
            if (channel == chan_temp_p) begin
                Temp_Result_o <= Conv_Data_i;
                Temp_Stages_o <= Conv_Div_Stages_i;
            end else begin
                Ldr_Result_o <= Conv_Data_i;
                Ldr_Stages_o <= Conv_Div_Stages_i;
            end
        end
    end

    assign Adc_Channel_o   = channel;
    assign Conv_Temp_LDR_o = channel;
    assign Timeout_Error_o = timeout_err;

endmodule

// File: tb/tb_sensor_scheduler.sv
// tb_sensor_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the scheduler.
module tb_sensor_scheduler;

    localparam int SP = 8;
    localparam int TO = 16;
    localparam int DW = 12;
    localparam int RW = 16;
    localparam int SW = 2;

    localparam int PH_IDLE   = 0;
    localparam int PH_PERIOD = 1;
    localparam int PH_ASTART = 2;
    localparam int PH_AWAIT  = 3;
    localparam int PH_CSTART = 4;
    localparam int PH_CWAIT  = 5;
    localparam int PH_STORE  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          adc_dv = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          conv_dv = 1'b0;
    logic [RW-1:0] conv_data = '0;
    logic [SW-1:0] conv_stg = '0;

    logic          adc_start;
    logic          adc_chan;
    logic          conv_tl;
    logic          conv_req;
    logic [DW-1:0] conv_dout;
    logic [RW-1:0] temp_res;
    logic [RW-1:0] ldr_res;
    logic [SW-1:0] temp_stg;
    logic [SW-1:0] ldr_stg;
    logic          res_valid;
    logic          res_chan;
    logic          t_err;

    sensor_scheduler #(
        .SAMPLE_PERIOD_P (SP),
        .TIMEOUT_P       (TO),
        .DATA_W_P        (DW),
        .RESULT_W_P      (RW),
        .STAGE_W_P       (SW)
    ) dut (
        .Clk_i                 (clk),
        .Reset_i               (rst_n),
        .Enable_i              (en),
        .Adc_Start_o           (adc_start),
        .Adc_Channel_o         (adc_chan),
        .Adc_Data_Available_i  (adc_dv),
        .Adc_Data_i            (adc_data),
        .Conv_Temp_LDR_o       (conv_tl),
        .Conv_Data_Available_o (conv_req),
        .Conv_Data_o           (conv_dout),
        .Conv_Data_Available_i (conv_dv),
        .Conv_Data_i           (conv_data),
        .Conv_Div_Stages_i     (conv_stg),
        .Temp_Result_o         (temp_res),
        .Ldr_Result_o          (ldr_res),
        .Temp_Stages_o         (temp_stg),
        .Ldr_Stages_o          (ldr_stg),
        .Result_Valid_o        (res_valid),
        .Result_Channel_o      (res_chan),
        .Timeout_Error_o       (t_err)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic rst_req = 1'b0;
    logic en_req = 1'b0;
    logic stray_conv = 1'b0;
    logic rand_mode = 1'b0;
    int   adc_delay = 0;
    int   conv_delay = 0;
    int   adc_cd = 0;
    int   conv_cd = 0;

    logic [DW-1:0] adc_q[$];
    logic [RW-1:0] conv_q[$];
    logic [SW-1:0] stg_q[$];

    int st_cyc[$];
    int st_ch[$];
    int cr_cyc[$];
    int cr_dat[$];
    int rv_cyc[$];
    int rv_ch[$];
    int err_cyc = -1;

    int            m_phase;
    int            m_since;
    logic          m_chan;
    logic [DW-1:0] m_cd;
    logic [RW-1:0] m_tr;
    logic [RW-1:0] m_lr;
    logic [SW-1:0] m_ts;
    logic [SW-1:0] m_ls;
    logic          m_rc;
    logic          m_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                      name, cyc, act, exp);
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_since = cyc;
        m_chan  = 1'b1;
        m_cd    = '0;
        m_tr    = '0;
        m_lr    = '0;
        m_ts    = '0;
        m_ls    = '0;
        m_rc    = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_check();
        chk("adc_start", 32'(adc_start), 32'(m_phase == PH_ASTART));
        chk("conv_req", 32'(conv_req), 32'(m_phase == PH_CSTART));
        chk("result_valid", 32'(res_valid), 32'(m_phase == PH_STORE));
        chk("adc_channel", 32'(adc_chan), 32'(m_chan));
        chk("conv_temp_ldr", 32'(conv_tl), 32'(m_chan));
        chk("conv_data", 32'(conv_dout), 32'(m_cd));
        chk("temp_result", 32'(temp_res), 32'(m_tr));
        chk("ldr_result", 32'(ldr_res), 32'(m_lr));
        chk("temp_stages", 32'(temp_stg), 32'(m_ts));
        chk("ldr_stages", 32'(ldr_stg), 32'(m_ls));
        chk("result_channel", 32'(res_chan), 32'(m_rc));
        chk("timeout_error", 32'(t_err), 32'(m_err));
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_step();
        int  nxt;
        int  age;
        logic expire;
        nxt = m_phase;
        age = cyc - m_since;
        expire = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (en) nxt = PH_ASTART;
                else m_err = 1'b0;
            end
            PH_PERIOD: begin
                if (!en) nxt = PH_IDLE;
                else if (age == SP - 1) nxt = PH_ASTART;
            end
            PH_ASTART: nxt = PH_AWAIT;
            PH_AWAIT: begin
                if (adc_dv) begin
                    m_cd = adc_data;
                    nxt = PH_CSTART;
                end else if (age == TO - 1) begin
                    expire = 1'b1;
                end
            end
            PH_CSTART: nxt = PH_CWAIT;
            PH_CWAIT: begin
                if (conv_dv) begin
                    if (m_chan) begin
                        m_tr = conv_data;
                        m_ts = conv_stg;
                    end else begin
                        m_lr = conv_data;
                        m_ls = conv_stg;
                    end
                    m_rc = m_chan;
                    nxt = PH_STORE;
                end else if (age == TO - 1) begin
                    expire = 1'b1;
                end
            end
            PH_STORE: begin
                m_chan = ~m_chan;
                nxt = en ? PH_PERIOD : PH_IDLE;
            end
            default: nxt = PH_IDLE;
        endcase
        if (expire) begin
            m_err = 1'b1;
            m_chan = ~m_chan;
            nxt = PH_PERIOD;
        end
        if (nxt != m_phase) m_since = cyc + 1;
        m_phase = nxt;
    endtask

    function automatic int pick_delay(input int fixed);
        if (!rand_mode) return fixed;
        if ($urandom_range(9) == 0) return 0;
        return int'($urandom_range(18, 1));
    endfunction

    task automatic observe();
        if (adc_start) begin
            st_cyc.push_back(cyc);
            st_ch.push_back(int'(adc_chan));
        end
        if (conv_req) begin
            cr_cyc.push_back(cyc);
            cr_dat.push_back(int'(conv_dout));
        end
        if (res_valid) begin
            rv_cyc.push_back(cyc);
            rv_ch.push_back(int'(res_chan));
        end
        if (t_err && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic clear_obs();
        st_cyc.delete();
        st_ch.delete();
        cr_cyc.delete();
        cr_dat.delete();
        rv_cyc.delete();
        rv_ch.delete();
        err_cyc = -1;
    endtask

    // One clock: drive inputs just after the edge, check at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = rst_req;
        en = en_req;
        adc_dv = 1'b0;
        conv_dv = 1'b0;
        if (!rst_n) begin
            adc_cd = 0;
            conv_cd = 0;
        end
        if (adc_cd > 0) begin
            adc_cd--;
            if (adc_cd == 0) begin
                adc_dv = 1'b1;
                if (adc_q.size() > 0) adc_data = adc_q.pop_front();
                else adc_data = DW'($urandom);
            end
        end
        if (conv_cd > 0) begin
            conv_cd--;
            if (conv_cd == 0) begin
                conv_dv = 1'b1;
                if (conv_q.size() > 0) conv_data = conv_q.pop_front();
                else conv_data = RW'($urandom);
                if (stg_q.size() > 0) conv_stg = stg_q.pop_front();
                else conv_stg = SW'($urandom);
            end
        end
        if (rst_n && adc_start) adc_cd = pick_delay(adc_delay);
        if (rst_n && conv_req) conv_cd = pick_delay(conv_delay);
        if (stray_conv) begin
            conv_dv = 1'b1;
            conv_data = RW'($urandom);
            conv_stg = SW'($urandom);
            stray_conv = 1'b0;
        end
        if (rand_mode) begin
            if ($urandom_range(49) == 0) begin
                adc_dv = 1'b1;
                adc_data = DW'($urandom);
            end
            if ($urandom_range(49) == 0) begin
                conv_dv = 1'b1;
                conv_data = RW'($urandom);
                conv_stg = SW'($urandom);
            end
        end
        @(negedge clk);
        if (!rst_n) model_reset();
        model_check();
        observe();
        if (rst_n) model_step();
    endtask

    task automatic do_reset();
        rst_req = 1'b0;
        en_req = 1'b0;
        rand_mode = 1'b0;
        adc_q.delete();
        conv_q.delete();
        stg_q.delete();
        tick();
        tick();
        rst_req = 1'b1;
        tick();
        clear_obs();
    endtask

    initial begin
        model_reset();

        // Reset values and normal round-robin
        do_reset();
        chk("rst_channel", 32'(adc_chan), 32'd1);
        chk("rst_temp", 32'(temp_res), 32'd0);
        chk("rst_err", 32'(t_err), 32'd0);
        chk("rst_res_chan", 32'(res_chan), 32'd0);
        adc_q.push_back(12'h0CD);
        adc_q.push_back(12'h3FF);
        conv_q.push_back(16'h0100);
        conv_q.push_back(16'h1023);
        stg_q.push_back(2'd2);
        stg_q.push_back(2'd3);
        adc_delay = 3;
        conv_delay = 4;
        en_req = 1'b1;
        for (int i = 0; i < 80 && rv_cyc.size() < 2; i++) tick();
        chk("s1_valid_count", 32'(rv_cyc.size()), 32'd2);
        if (rv_cyc.size() >= 2 && st_cyc.size() >= 2 && cr_cyc.size() >= 2) begin
            chk("s1_start0_chan", 32'(st_ch[0]), 32'd1);
            chk("s1_start1_chan", 32'(st_ch[1]), 32'd0);
            chk("s1_valid0_chan", 32'(rv_ch[0]), 32'd1);
            chk("s1_valid1_chan", 32'(rv_ch[1]), 32'd0);
            chk("s1_conv0_data", 32'(cr_dat[0]), 32'h0CD);
            chk("s1_conv1_data", 32'(cr_dat[1]), 32'h3FF);
            chk("s1_temp_res", 32'(temp_res), 32'h0100);
            chk("s1_temp_stg", 32'(temp_stg), 32'd2);
            chk("s1_ldr_res", 32'(ldr_res), 32'h1023);
            chk("s1_ldr_stg", 32'(ldr_stg), 32'd3);
            chk("s1_round_len", 32'(rv_cyc[0] - st_cyc[0]), 32'd9);
            chk("s1_spacing", 32'(st_cyc[1] - rv_cyc[0]), 32'd9);
        end

        // ADC never answers
        do_reset();
        adc_delay = 0;
        conv_delay = 1;
        en_req = 1'b1;
        for (int i = 0; i < 80 && st_cyc.size() < 2; i++) tick();
        chk("s2_starts", 32'(st_cyc.size()), 32'd2);
        if (st_cyc.size() >= 2) begin
            chk("s2_err_at", 32'(err_cyc - st_cyc[0]), 32'd17);
            chk("s2_restart_at", 32'(st_cyc[1] - st_cyc[0]), 32'd25);
            chk("s2_next_chan", 32'(st_ch[1]), 32'd0);
            chk("s2_err", 32'(t_err), 32'd1);
            chk("s2_temp_res", 32'(temp_res), 32'd0);
            chk("s2_conv_reqs", 32'(cr_cyc.size()), 32'd0);
        end

        // Converter never answers
        do_reset();
        adc_delay = 2;
        conv_delay = 0;
        en_req = 1'b1;
        for (int i = 0; i < 80 && st_cyc.size() < 2; i++) tick();
        chk("s3_starts", 32'(st_cyc.size()), 32'd2);
        chk("s3_conv_reqs", 32'(cr_cyc.size()), 32'd1);
        chk("s3_valids", 32'(rv_cyc.size()), 32'd0);
        if (cr_cyc.size() >= 1) begin
            chk("s3_err_at", 32'(err_cyc - cr_cyc[0]), 32'd17);
        end

        // Data on the final wait cycle wins over the timeout
        do_reset();
        adc_delay = 16;
        conv_delay = 1;
        en_req = 1'b1;
        for (int i = 0; i < 80 && rv_cyc.size() < 1; i++) tick();
        chk("s4_valids", 32'(rv_cyc.size()), 32'd1);
        chk("s4_no_err", 32'(err_cyc), 32'hFFFF_FFFF);
        if (cr_cyc.size() >= 1 && st_cyc.size() >= 1) begin
            chk("s4_accept_at", 32'(cr_cyc[0] - st_cyc[0]), 32'd17);
        end

        // Enable dropped during the converter wait
        do_reset();
        adc_delay = 0;
        conv_delay = 5;
        en_req = 1'b1;
        for (int i = 0; i < 60 && !t_err; i++) tick();
        chk("s5_err_set", 32'(t_err), 32'd1);
        adc_delay = 3;
        clear_obs();
        conv_q.push_back(16'h0420);
        stg_q.push_back(2'd1);
        for (int i = 0; i < 60 && cr_cyc.size() < 1; i++) tick();
        chk("s5_conv_req", 32'(cr_cyc.size()), 32'd1);
        en_req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("s5_valids", 32'(rv_cyc.size()), 32'd1);
        chk("s5_starts", 32'(st_cyc.size()), 32'd1);
        chk("s5_err_cleared", 32'(t_err), 32'd0);
        chk("s5_ldr_res", 32'(ldr_res), 32'h0420);
        chk("s5_channel", 32'(adc_chan), 32'd1);

        // Reset in the middle of a round, then a stray converter pulse
        do_reset();
        adc_delay = 0;
        conv_delay = 0;
        en_req = 1'b1;
        for (int i = 0; i < 20 && st_cyc.size() < 1; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        rst_req = 1'b0;
        tick();
        tick();
        en_req = 1'b0;
        rst_req = 1'b1;
        tick();
        clear_obs();
        stray_conv = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("s6_valids", 32'(rv_cyc.size()), 32'd0);
        chk("s6_starts", 32'(st_cyc.size()), 32'd0);
        chk("s6_temp_res", 32'(temp_res), 32'd0);
        chk("s6_ldr_res", 32'(ldr_res), 32'd0);
        chk("s6_conv_data", 32'(conv_dout), 32'd0);
        chk("s6_channel", 32'(adc_chan), 32'd1);
        chk("s6_err", 32'(t_err), 32'd0);

        // Randomized traffic against the model
        do_reset();
        rand_mode = 1'b1;
        adc_delay = 1;
        conv_delay = 1;
        en_req = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (en_req && $urandom_range(149) == 0) en_req = 1'b0;
            else if (!en_req && $urandom_range(19) == 0) en_req = 1'b1;
            if (!rst_req) rst_req = 1'b1;
            else if ($urandom_range(1499) == 0) rst_req = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
